// File: rtl/meter_ctrl.sv
// ---------------------------------------------------------------------------
// meter_ctrl
//
// Purpose:
//   Sequencing controller for the parking-meter time register. It merges the
//   one-cycle coin/add pulses, the preset pulses and an internally generated
//   1-second tick into one saturating countdown value. The remaining time is
//   classified as RUN / LOW / EXPIRED, and a display-enable blink pattern is
//   produced for the seven-segment driver.
//
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous, active-low reset
//   add_req   in   [3:0] one-cycle add pulses, bit i adds ADDi seconds
//   preset    in   [1:0] one-cycle preset pulses (bit 0 wins over bit 1)
//   count     out  [15:0] remaining seconds, 0..MAX_COUNT
//   state     out  [1:0] 00 EXPIRED, 01 LOW, 10 RUN
//   expired   out  high while state is EXPIRED
//   blink_on  out  display enable (steady in RUN, 1 Hz in LOW, 2 Hz in EXPIRED)
//   tick      out  one-cycle pulse once per second
// ---------------------------------------------------------------------------
module meter_ctrl #(
  parameter int TICK_DIV   = 100000000,
  parameter int MAX_COUNT  = 9999,
  parameter int LOW_THRESH = 200,
  parameter int ADD0       = 10,
  parameter int ADD1       = 180,
  parameter int ADD2       = 200,
  parameter int ADD3       = 550,
  parameter int PRESET0    = 10,
  parameter int PRESET1    = 205
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  add_req,
  input  logic [1:0]  preset,
  output logic [15:0] count,
  output logic [1:0]  state,
  output logic        expired,
  output logic        blink_on,
  output logic        tick
);

  typedef enum logic [1:0] {
    ST_EXPIRED = 2'b00,
    ST_LOW     = 2'b01,
    ST_RUN     = 2'b10
  } meter_state_e;

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(TICK_DIV / 2 - 1);

  // Arithmetic is carried out in 17 bits so count + all four adds never wraps
  // before the clamp is applied.
  localparam logic [16:0] ADD0_W  = 17'(ADD0);
  localparam logic [16:0] ADD1_W  = 17'(ADD1);
  localparam logic [16:0] ADD2_W  = 17'(ADD2);
  localparam logic [16:0] ADD3_W  = 17'(ADD3);
  localparam logic [16:0] MAX_W   = 17'(MAX_COUNT);
  localparam logic [15:0] MAX16   = 16'(MAX_COUNT);
  localparam logic [15:0] LOW16   = 16'(LOW_THRESH);
  localparam logic [15:0] PRESET0_W = 16'(PRESET0);
  localparam logic [15:0] PRESET1_W = 16'(PRESET1);

  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick_q, tick_d;
  logic             tick_fire;
  logic             half_fire;

  logic [16:0]      add_sum;
  logic [16:0]      sum_ext;
  logic [15:0]      count_q, count_d;

  meter_state_e     state_q, state_d;
  logic             expired_q, expired_d;
  logic             blink_q, blink_d;
  logic             sec_phase_q, sec_phase_d;
  logic             half_phase_q, half_phase_d;

  // Free-running prescaler. The full-second strobe is the last count of the
  // period; the half-second strobe fires at the midpoint and at the end so the
  // EXPIRED blink gets two toggles per second. The visible tick output is the
  // registered copy of the full-second strobe.
  always_comb begin
    tick_fire  = (tick_cnt_q == TICK_LAST);
    half_fire  = (tick_cnt_q == HALF_LAST) || tick_fire;
    tick_cnt_d = tick_fire ? '0 : tick_cnt_q + CNT_W'(1);
    tick_d     = tick_fire;
  end

  // Count update. Presets override everything (bit 0 has priority). Otherwise
  // every asserted add bit is honoured, and a tick takes one second off only
  // when there is time left, so a tick arriving with an add at zero yields
  // exactly the add amount. The result is clamped to the ceiling.
  always_comb begin
    add_sum = (add_req[0] ? ADD0_W : 17'd0)
            + (add_req[1] ? ADD1_W : 17'd0)
            + (add_req[2] ? ADD2_W : 17'd0)
            + (add_req[3] ? ADD3_W : 17'd0);
    sum_ext = {1'b0, count_q} + add_sum;
    if (tick_fire && (count_q != 16'd0)) begin
      sum_ext = sum_ext - 17'd1;
    end

    if (preset[0]) begin
      count_d = PRESET0_W;
    end else if (preset[1]) begin
      count_d = PRESET1_W;
    end else if (sum_ext > MAX_W) begin
      count_d = MAX16;
    end else begin
      count_d = sum_ext[15:0];
    end
  end

  // State is derived from the next count so it lands on the same edge as the
  // count itself.
  always_comb begin
    if (count_d == 16'd0) begin
      state_d = ST_EXPIRED;
    end else if (count_d < LOW16) begin
      state_d = ST_LOW;
    end else begin
      state_d = ST_RUN;
    end
    expired_d = (state_d == ST_EXPIRED);
  end

  // Blink pattern. Each phase bit is cleared when its state is entered so the
  // display always starts "on"; afterwards it toggles on its own strobe. The
  // blink output follows the new phase value so it is aligned with state.
  always_comb begin
    sec_phase_d  = sec_phase_q;
    half_phase_d = half_phase_q;
    blink_d      = 1'b1;
    case (state_d)
      ST_LOW: begin
        if (state_q != ST_LOW) begin
          sec_phase_d = 1'b0;
        end else if (tick_fire) begin
          sec_phase_d = ~sec_phase_q;
        end
        blink_d = ~sec_phase_d;
      end
      ST_EXPIRED: begin
        if (state_q != ST_EXPIRED) begin
          half_phase_d = 1'b0;
        end else if (half_fire) begin
          half_phase_d = ~half_phase_q;
        end
        blink_d = ~half_phase_d;
      end
      ST_RUN: begin
        blink_d = 1'b1;
      end
      default: begin
        blink_d = 1'b1;
      end
    endcase
  end

  // All state lives in this one register bank; reset drops everything to
  // an empty, expired meter with the display on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q   <= '0;
      tick_q       <= 1'b0;
      count_q      <= 16'd0;
      state_q      <= ST_EXPIRED;
      expired_q    <= 1'b1;
      blink_q      <= 1'b1;
      sec_phase_q  <= 1'b0;
      half_phase_q <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      tick_q       <= tick_d;
      count_q      <= count_d;
      state_q      <= state_d;
      expired_q    <= expired_d;
      blink_q      <= blink_d;
      sec_phase_q  <= sec_phase_d;
      half_phase_q <= half_phase_d;
    end
  end

  assign count    = count_q;
  assign state    = state_q;
  assign expired  = expired_q;
  assign blink_on = blink_q;
  assign tick     = tick_q;

endmodule

// File: tb/tb_meter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_meter_ctrl
//
// Directed bench for meter_ctrl with a 10-cycle second. Edge numbers in the
// comments count rising clock edges after reset release (E1 is the first);
// the prescaler fires a tick on E10, E20, ... and a half-tick every 5 edges.
// ---------------------------------------------------------------------------
module tb_meter_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  add_req = 4'd0;
  logic [1:0]  preset = 2'd0;
  logic [15:0] count;
  logic [1:0]  state;
  logic        expired;
  logic        blink_on;
  logic        tick;

  int num_checks = 0;
  int num_errors = 0;

  meter_ctrl #(
    .TICK_DIV(10)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .add_req  (add_req),
    .preset   (preset),
    .count    (count),
    .state    (state),
    .expired  (expired),
    .blink_on (blink_on),
    .tick     (tick)
  );

  // 10-time-unit clock: rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    assert (observed === expected)
    else begin
      num_errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Checks count, state, expired and tick against hand-derived values.
  task automatic checkAll(input string tag, input logic [15:0] exp_count,
                          input logic [1:0] exp_state, input logic exp_tick);
    checkOutput({tag, ".count"},   32'(count),   32'(exp_count));
    checkOutput({tag, ".state"},   32'(state),   32'(exp_state));
    checkOutput({tag, ".expired"}, 32'(expired), 32'(exp_state == 2'b00));
    checkOutput({tag, ".tick"},    32'(tick),    32'(exp_tick));
  endtask

  // Drives a one-cycle pulse: set at a falling edge, sampled by the next
  // rising edge, cleared at the following falling edge.
  task automatic applyStimulus(input logic [3:0] a, input logic [1:0] p);
    add_req = a;
    preset  = p;
    @(negedge clk);
    add_req = 4'd0;
    preset  = 2'd0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Directed sequence; all checks happen on falling edges.
  initial begin
    // Reset held across a couple of clocks
    #2 reset_n = 1'b0;
    waitCycles(2);
    checkAll("reset", 16'd0, 2'b00, 1'b0);
    checkOutput("reset.blink", 32'(blink_on), 32'd1);
    reset_n = 1'b1;

    // Idle after release: blink toggles every 5 edges, tick every 10
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      checkAll("idle", 16'd0, 2'b00, 1'(k % 10 == 0));
      checkOutput("idle.blink", 32'(blink_on), 32'(((k / 5) % 2) == 0));
    end

    // preset[1] captured on E31
    applyStimulus(4'd0, 2'b10);
    checkAll("preset1", 16'd205, 2'b10, 1'b0);
    checkOutput("preset1.blink", 32'(blink_on), 32'd1);

    // Ticks E40..E80 bring it to 200 (still RUN), E90 to 199 (LOW)
    waitCycles(58);
    checkAll("at_thresh", 16'd200, 2'b10, 1'b0);
    waitCycles(1);
    checkAll("enter_low", 16'd199, 2'b01, 1'b1);
    checkOutput("enter_low.blink", 32'(blink_on), 32'd1);
    waitCycles(9);
    checkAll("low_on_end", 16'd199, 2'b01, 1'b0);
    checkOutput("low_on_end.blink", 32'(blink_on), 32'd1);
    waitCycles(1);
    checkAll("low_off", 16'd198, 2'b01, 1'b1);
    checkOutput("low_off.blink", 32'(blink_on), 32'd0);
    waitCycles(9);
    checkOutput("low_off_end.blink", 32'(blink_on), 32'd0);
    waitCycles(1);
    checkAll("low_on2", 16'd197, 2'b01, 1'b1);
    checkOutput("low_on2.blink", 32'(blink_on), 32'd1);

    // preset[0] on E111, then ten ticks E120..E210 run it down to zero
    applyStimulus(4'd0, 2'b01);
    checkAll("preset0", 16'd10, 2'b01, 1'b0);
    waitCycles(98);
    checkAll("last_sec", 16'd1, 2'b01, 1'b0);
    waitCycles(1);
    checkAll("run_out", 16'd0, 2'b00, 1'b1);
    checkOutput("run_out.blink", 32'(blink_on), 32'd1);
    waitCycles(5);
    checkOutput("exp_half.blink", 32'(blink_on), 32'd0);
    waitCycles(5);
    checkAll("tick_at_zero", 16'd0, 2'b00, 1'b1);
    checkOutput("tick_at_zero.blink", 32'(blink_on), 32'd1);

    // Add 10 held from E230 (a tick edge at zero: no decrement) to E239
    waitCycles(9);
    add_req = 4'b0001;
    @(negedge clk);
    checkAll("tick_add_zero", 16'd10, 2'b01, 1'b1);
    waitCycles(9);
    checkAll("built_100", 16'd100, 2'b01, 1'b0);

    // All four adds with the E240 tick: 100 + 940 - 1
    add_req = 4'b1111;
    @(negedge clk);
    add_req = 4'd0;
    checkAll("all_adds_tick", 16'd1039, 2'b10, 1'b1);

    // Preset priority over adds, and preset[0] over preset[1]
    applyStimulus(4'b1000, 2'b01);
    checkAll("preset_over_add", 16'd10, 2'b01, 1'b0);
    applyStimulus(4'd0, 2'b10);
    checkAll("preset1_again", 16'd205, 2'b10, 1'b0);
    applyStimulus(4'd0, 2'b11);
    checkAll("both_presets", 16'd10, 2'b01, 1'b0);

    // Held adds E244..E254 saturate; tick plus add at the ceiling on E260
    add_req = 4'b1111;
    waitCycles(11);
    checkAll("saturate", 16'd9999, 2'b10, 1'b0);
    waitCycles(6);
    add_req = 4'd0;
    checkAll("max_tick_add", 16'd9999, 2'b10, 1'b1);

    // Nine ticks E270..E350 reach 9990, then add 550 clamps to 9999
    waitCycles(90);
    checkAll("at_9990", 16'd9990, 2'b10, 1'b1);
    applyStimulus(4'b1000, 2'b00);
    checkAll("clamp_9990", 16'd9999, 2'b10, 1'b0);
    waitCycles(9);
    checkAll("countdown", 16'd9998, 2'b10, 1'b1);

    // Asynchronous reset between clock edges
    #2 reset_n = 1'b0;
    #1;
    checkAll("async_reset", 16'd0, 2'b00, 1'b0);
    checkOutput("async_reset.blink", 32'(blink_on), 32'd1);

    // Release: prescaler restarts from zero, first tick on the tenth edge
    @(negedge clk);
    reset_n = 1'b1;
    waitCycles(9);
    checkAll("restart_pre_tick", 16'd0, 2'b00, 1'b0);
    waitCycles(1);
    checkAll("restart_tick", 16'd0, 2'b00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
